univ_gate_tt_checker: RTL

Sequencer that drives the two inputs of a switch-level universal gate (NOR by default) through all four input combinations. After each vector it waits a settle window, samples the gate output and compares it with an expected truth table. It reports per-vector failures, a mismatch count and a pass flag. It sits in the Day-series test harness beside the gate under test and replaces hand-written stimulus.

---
 rtl/univ_gate_tt_checker_if.sv | 24 ++
 rtl/univ_gate_tt_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/univ_gate_tt_checker_if.sv
// rtl/univ_gate_tt_checker_if.sv - control and gate-side signals of the truth-table checker
// slave is the checker; master is whoever drives start/abort and hosts the gate under test.
interface univ_gate_tt_checker_if;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [7:0] err_count;

  modport master (
    output start, abort, dut_out,
    input  dut_a, dut_b, busy, done, pass, fail_vec, err_count
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_a, dut_b, busy, done, pass, fail_vec, err_count
  );
endinterface

// File: rtl/univ_gate_tt_checker.sv
// rtl/univ_gate_tt_checker.sv - walks a 2-input gate through 00,01,10,11 and checks its truth table
// Each vector is held SETTLE_CYCLES cycles, then sampled in a CHECK cycle; LOOPS passes per run.
module univ_gate_tt_checker #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXP_TT        = 4'b0001,
  parameter int         LOOPS         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  univ_gate_tt_checker_if.slave   io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LOOP_LAST = 4'(LOOPS - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] loop_q, loop_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [7:0] err_count_q, err_count_d;
  logic       mismatch;

  // Case inequality so that an X or Z on the gate output is never taken as a match.
  assign mismatch = (io.dut_out !== EXP_TT[idx_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 8'd0;
      loop_q      <= 4'd0;
      ab_q        <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 4'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      loop_q      <= loop_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    loop_d      = loop_q;
    ab_d        = ab_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;

    case (state_q)
      IDLE: begin
        if (io.start && !io.abort) begin
          idx_d       = 2'd0;
          cnt_d       = 8'd0;
          loop_d      = 4'd0;
          ab_d        = 2'b00;
          fail_vec_d  = 4'd0;
          err_count_d = 8'd0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = APPLY;
        end
      end

      APPLY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (mismatch) begin
          fail_vec_d[idx_q] = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
          cnt_d   = 8'd0;
          state_d = APPLY;
        end else if (loop_q != LOOP_LAST) begin
          loop_d  = loop_q + 4'd1;
          idx_d   = 2'd0;
          ab_d    = 2'b00;
          cnt_d   = 8'd0;
          state_d = APPLY;
        end else begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == 8'd0);
        busy_d  = 1'b0;
        ab_d    = 2'b00;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever APPLY/CHECK decided; partial fail_vec/err_count stay for debug.
    if (io.abort && (state_q == APPLY || state_q == CHECK)) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      ab_d        = 2'b00;
      pass_d      = 1'b0;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      loop_d      = loop_q;
      fail_vec_d  = fail_vec_q;
      err_count_d = err_count_q;
    end
  end

  assign io.dut_a     = ab_q[1];
  assign io.dut_b     = ab_q[0];
  assign io.busy      = busy_q;
  assign io.done      = done_q;
  assign io.pass      = pass_q;
  assign io.fail_vec  = fail_vec_q;
  assign io.err_count = err_count_q;

endmodule
